// File: rtl/lc3_controller.sv
// Pipeline sequencer for a 4-stage LC-3 core: fills the pipe, stalls on instruction
// misses, sequences data-memory accesses and inserts branch bubbles.
module lc3_controller #(
    parameter int BR_BUBBLES = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        complete_instr,
    input  logic        complete_data,
    input  logic [15:0] IR,
    input  logic [15:0] IR_Exec,
    input  logic [2:0]  NZP,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        enable_updatePC,
    output logic        br_taken,
    output logic [1:0]  mem_state
);

    typedef enum logic [1:0] {FILL, RUN, MEM, CTRL} state_t;

    localparam logic [1:0] MS_READ  = 2'd0;
    localparam logic [1:0] MS_IND   = 2'd1;
    localparam logic [1:0] MS_WRITE = 2'd2;
    localparam logic [1:0] MS_IDLE  = 2'd3;
    localparam logic [2:0] BUBBLE_LOAD = 3'(BR_BUBBLES - 1);

    function automatic logic is_mem_op(input logic [3:0] op);
        case (op)
            4'b0010, 4'b0110, 4'b1010, 4'b0011, 4'b0111, 4'b1011: is_mem_op = 1'b1;
            default:                                              is_mem_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_ctrl_op(input logic [3:0] op);
        is_ctrl_op = (op == 4'b0000) || (op == 4'b1100);
    endfunction

    state_t     state_q, state_d;
    logic       v_dec_q, v_dec_d, v_exe_q, v_exe_d, v_wb_q, v_wb_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] ms_d;
    logic       mem_load_q, mem_load_d;
    logic       ret_ctrl_q, ret_ctrl_d;
    logic       ctrl_jmp_q, ctrl_jmp_d;
    logic       exe_done_q, exe_done_d;
    logic       br_d;
    logic       en_fetch_d, en_dec_d, en_exe_d, en_wb_d, en_upc_d;

    logic       mem_hit;
    logic [1:0] first_ms;
    logic       unused_ir_bits;

    // A load/store stays in IR_Exec for one cycle after its access completes,
    // so exe_done keeps it from being launched a second time.
    assign mem_hit  = v_exe_q && !exe_done_q && is_mem_op(IR_Exec[15:12]);
    assign first_ms = (IR_Exec[15:14] == 2'b10) ? MS_IND :
                      (IR_Exec[12] ? MS_WRITE : MS_READ);
    assign unused_ir_bits = ^{IR[11:0], IR_Exec[8:0]};

    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        state_d    = state_q;
        v_dec_d    = v_dec_q;
        v_exe_d    = v_exe_q;
        v_wb_d     = v_wb_q;
        cnt_d      = cnt_q;
        ms_d       = mem_state;
        mem_load_d = mem_load_q;
        ret_ctrl_d = ret_ctrl_q;
        ctrl_jmp_d = ctrl_jmp_q;
        exe_done_d = 1'b0;
        br_d       = 1'b0;
        en_fetch_d = 1'b0;
        en_dec_d   = 1'b0;
        en_exe_d   = 1'b0;
        en_wb_d    = 1'b0;
        en_upc_d   = 1'b0;

        case (state_q)
            FILL: begin
                en_fetch_d = 1'b1;
                en_upc_d   = 1'b1;
                en_dec_d   = 1'b1;
                en_exe_d   = v_dec_q;
                en_wb_d    = v_exe_q;
                v_dec_d    = 1'b1;
                v_exe_d    = v_dec_q;
                v_wb_d     = v_exe_q;
                if (v_exe_q) state_d = RUN;
            end

            RUN, CTRL: begin
                if (mem_hit) begin
                    // The bubble count is left untouched so CTRL resumes where it stopped.
                    state_d    = MEM;
                    ms_d       = first_ms;
                    mem_load_d = !IR_Exec[12];
                    ret_ctrl_d = (state_q == CTRL);
                end else if (state_q == CTRL) begin
                    v_exe_d = v_dec_q;
                    v_wb_d  = v_exe_q;
                    en_dec_d = 1'b1;
                    en_exe_d = 1'b1;
                    en_wb_d  = 1'b1;
                    if (cnt_q == 3'd0) begin
                        br_d       = ctrl_jmp_q || (|(IR_Exec[11:9] & NZP));
                        en_fetch_d = 1'b1;
                        en_upc_d   = 1'b1;
                        v_dec_d    = 1'b1;
                        state_d    = RUN;
                    end else begin
                        cnt_d   = cnt_q - 3'd1;
                        v_dec_d = 1'b0;
                    end
                end else if (v_dec_q && is_ctrl_op(IR[15:12])) begin
                    state_d    = CTRL;
                    cnt_d      = BUBBLE_LOAD;
                    ctrl_jmp_d = (IR[15:12] == 4'b1100);
                    en_dec_d   = 1'b1;
                    en_exe_d   = 1'b1;
                    en_wb_d    = 1'b1;
                    v_dec_d    = 1'b0;
                    v_exe_d    = v_dec_q;
                    v_wb_d     = v_exe_q;
                end else if (complete_instr) begin
                    en_fetch_d = 1'b1;
                    en_dec_d   = 1'b1;
                    en_exe_d   = 1'b1;
                    en_wb_d    = 1'b1;
                    en_upc_d   = 1'b1;
                    v_dec_d    = 1'b1;
                    v_exe_d    = v_dec_q;
                    v_wb_d     = v_exe_q;
                end
            end

            MEM: begin
                if (complete_data) begin
                    if (mem_state == MS_IND) begin
                        ms_d = mem_load_q ? MS_READ : MS_WRITE;
                    end else begin
                        ms_d       = MS_IDLE;
                        en_wb_d    = mem_load_q;
                        exe_done_d = 1'b1;
                        state_d    = ret_ctrl_q ? CTRL : RUN;
                    end
                end
            end

            default: state_d = FILL;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= FILL;
            v_dec_q          <= 1'b0;
            v_exe_q          <= 1'b0;
            v_wb_q           <= 1'b0;
            cnt_q            <= 3'd0;
            mem_state        <= MS_IDLE;
            mem_load_q       <= 1'b0;
            ret_ctrl_q       <= 1'b0;
            ctrl_jmp_q       <= 1'b0;
            exe_done_q       <= 1'b0;
            br_taken         <= 1'b0;
            enable_fetch     <= 1'b1;
            enable_decode    <= 1'b0;
            enable_execute   <= 1'b0;
            enable_writeback <= 1'b0;
            enable_updatePC  <= 1'b1;
        end else begin
            state_q          <= state_d;
            v_dec_q          <= v_dec_d;
            v_exe_q          <= v_exe_d;
            v_wb_q           <= v_wb_d;
            cnt_q            <= cnt_d;
            mem_state        <= ms_d;
            mem_load_q       <= mem_load_d;
            ret_ctrl_q       <= ret_ctrl_d;
            ctrl_jmp_q       <= ctrl_jmp_d;
            exe_done_q       <= exe_done_d;
            br_taken         <= br_d;
            enable_fetch     <= en_fetch_d;
            enable_decode    <= en_dec_d;
            enable_execute   <= en_exe_d;
            enable_writeback <= en_wb_d;
            enable_updatePC  <= en_upc_d;
        end
    end

endmodule

// File: doc/lc3_controller.md
LC3_CONTROLLER -- requirements
Module: lc3_controller

Interface
REQ-001 Parameter BR_BUBBLES, default 3: cycles fetch is held after a control instruction enters decode; range 2..7.
REQ-002 clock  input  1  single clock for the block; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low; low forces the reset state immediately, independent of clock.
REQ-004 complete_instr  input  1  instruction memory returned valid data this cycle.
REQ-005 complete_data  input  1  data memory finished the access requested by the current mem_state.
REQ-006 IR  input  16  instruction held in the decode output register (decode stage).
REQ-007 IR_Exec  input  16  instruction held in the execute stage.
REQ-008 NZP  input  3  condition codes from writeback: {N,Z,P}.
REQ-009 enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC  output  1 each  stage advance enables.
REQ-010 br_taken  output  1  one-cycle pulse; PC loads the computed target when high.
REQ-011 mem_state  output  2  0 = read data, 1 = read indirect address, 2 = write data, 3 = idle.

Function
REQ-012 All outputs shall be registered.
REQ-013 State machine states: FILL, RUN, MEM, CTRL; internal valid bits v_dec, v_exe, v_wb.
REQ-014 FILL: enable_fetch and enable_updatePC high; v_dec, v_exe, v_wb set on successive cycles; enable_decode, enable_execute, enable_writeback rise on the cycle their stage becomes valid; FILL -> RUN once v_wb = 1.
REQ-015 RUN: all five enables high while complete_instr = 1.
REQ-016 RUN with complete_instr = 0: all five enables low for that cycle; valid bits and state are held.
REQ-017 Memory ops are opcode[1] = 1 (LD 0010, LDR 0110, LDI 1010, LEA 1110, ST 0011, STR 0111, STI 1011); LEA (1110) is excluded and never enters MEM.
REQ-018 RUN -> MEM on the cycle v_exe = 1 and IR_Exec is a memory op. In MEM, all enables are low except as REQ-022 states.
REQ-019 First mem_state on MEM entry: LD/LDR -> 0; ST/STR -> 2; LDI/STI -> 1.
REQ-020 From mem_state 1 with complete_data = 1: LDI -> 0, STI -> 2.
REQ-021 mem_state 0 or 2 with complete_data = 1 ends the access: mem_state -> 3; next state RUN.
REQ-022 On the MEM exit cycle, enable_writeback shall be high for loads (LD, LDR, LDI) and low for stores.
REQ-023 Without complete_data, mem_state shall hold indefinitely; no timeout.
REQ-024 Control ops are opcode 0000 (BR) and 1100 (JMP).
REQ-025 RUN -> CTRL when v_dec = 1 and IR is a control op. In CTRL, enable_fetch and enable_updatePC are low, and a bubble counter loads BR_BUBBLES-1 and decrements each cycle.
REQ-026 While in CTRL, enable_decode, enable_execute and enable_writeback stay high so the branch drains through the pipeline; the bubble inserted in decode clears v_dec.
REQ-027 When the bubble counter reaches 0: JMP sets br_taken = 1. BR sets br_taken = |(IR_Exec[11:9] & NZP). enable_updatePC = 1 for that one cycle; next state RUN.
REQ-028 A memory op reaching execute during CTRL has priority: the counter freezes, MEM runs to completion, then CTRL resumes with the frozen count.
REQ-029 br_taken shall be high for at most one cycle per control op and never outside CTRL.
REQ-030 BR with IR_Exec[11:9] = 000 is never taken; with 111 it is always taken.

Reset
REQ-031 While reset is low: state FILL; valid bits 0; bubble counter 0; mem_state 3; br_taken 0; enable_fetch and enable_updatePC 1; enable_decode, enable_execute, enable_writeback 0.
REQ-032 Reset asserted mid-MEM or mid-CTRL shall abort the operation immediately, with no further br_taken pulse or mem_state change.
REQ-033 After reset deasserts, the block leaves FILL no earlier than the third rising edge.

Verification
REQ-034 Release reset with complete_instr = 1 and an ADD stream -> enable_decode rises at edge 1, enable_execute at edge 2, enable_writeback at edge 3; RUN thereafter with all enables 1.
REQ-035 LDI (IR_Exec = 16'hA000), complete_data pulsed at 2-cycle intervals -> mem_state 1, then 0, then 3; enables low throughout; enable_writeback = 1 on the exit cycle.
REQ-036 STR (16'h7000), complete_data held 0 for 10 cycles then 1 -> mem_state 2 for 11 cycles, then 3; enable_writeback stays 0.
REQ-037 BR (IR = 16'h0401, IR_Exec[11:9] = 010), NZP = 010, BR_BUBBLES = 3 -> fetch low 3 cycles, then br_taken = 1 for one cycle. Repeat with NZP = 100 -> br_taken = 0 and enable_updatePC = 1.
REQ-038 JMP (16'hC1C0) followed by LD in execute during CTRL -> MEM completes first, then br_taken = 1 exactly once.
REQ-039 Assert reset during mem_state 1 -> mem_state = 3 and enables return to the REQ-031 values within the same cycle, without a clock edge.
